uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters: N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameters: ACK_TIMEOUT, default 64, maximum number of CLK cycles to wait for uart_send to accept a byte.
REQ-003 CLK  input  1  the single clock; all logic is on its rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 REQ_VALID  input  N_REQ  per-requester byte-valid flag; held high until that requester's REQ_ACK.
REQ-006 REQ_DATA  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 REQ_LAST  input  N_REQ  per-requester flag; marks this byte as the final byte of the requester's message.
REQ-008 REQ_ACK  output  N_REQ  one-cycle pulse; the byte of requester i has been latched.
REQ-009 TX_DATA  output  8  byte to uart_send DATA.
REQ-010 TX_DATA_READY  output  1  to uart_send DATA_READY.
REQ-011 TX_IDLE  input  1  from uart_send IDLE.
REQ-012 GRANT  output  N_REQ  one-hot owner of the UART; all zero when unowned.
REQ-013 BUSY  output  1  high whenever the FSM is not in S_IDLE.
REQ-014 TIMEOUT_ERR  output  1  one-cycle pulse on an accept timeout.

Function
REQ-015 FSM states: S_IDLE, S_LOAD, S_WAIT.
REQ-016 S_IDLE, when TX_IDLE=1 and an eligible REQ_VALID is high: latch REQ_DATA into TX_DATA, pulse REQ_ACK for that requester, set GRANT, and go to S_LOAD. All of this happens on the next edge, so REQ_ACK is seen one cycle after REQ_VALID.
REQ-017 S_IDLE with TX_IDLE=0: no grant, no ACK; the FSM waits.
REQ-018 Eligibility when unlocked: any requester, chosen round-robin. The search starts at (last granted index + 1) mod N_REQ; the first asserted REQ_VALID in ascending wrap-around order wins.
REQ-019 Eligibility when locked: only the locked requester is eligible; every other REQ_VALID is ignored.
REQ-020 Lock rules:
- The lock is set when a byte with REQ_LAST=0 is granted.
- The lock is cleared when a byte with REQ_LAST=1 is granted.
- GRANT stays on the locked requester between bytes.
REQ-021 S_LOAD:
- TX_DATA_READY=1 and TX_DATA is held stable.
- On TX_IDLE=0: TX_DATA_READY=0 on the next edge, go to S_WAIT.
REQ-022 S_LOAD timeout: after ACK_TIMEOUT cycles in S_LOAD with TX_IDLE still 1:
- TX_DATA_READY=0 and TIMEOUT_ERR pulses.
- The byte is dropped and the lock is cleared.
- GRANT goes to 0 and the FSM goes to S_IDLE.
REQ-023 S_WAIT: on TX_IDLE=1, go to S_IDLE. GRANT goes to 0 at the same time, unless the lock is held.
REQ-024 REQ_ACK is at most one-hot and is never asserted outside the S_IDLE->S_LOAD transition.
REQ-025 TX_DATA changes only on the S_IDLE->S_LOAD transition.
REQ-026 A requester dropping REQ_VALID before its ACK is legal and simply forfeits arbitration.
REQ-027 Timeout counter width: clog2(ACK_TIMEOUT+1). The counter clears on entry to S_LOAD and saturates at its maximum.

Reset
REQ-028 While RST=1, on each edge:
- FSM goes to S_IDLE.
- Lock is cleared and the round-robin pointer is set to N_REQ-1, so requester 0 has first priority.
- Outputs are driven low: TX_DATA=0, TX_DATA_READY=0, REQ_ACK=0, GRANT=0, BUSY=0, TIMEOUT_ERR=0.
REQ-029 RST asserted mid-transfer aborts immediately. No ACK or error pulse is generated. After RST falls, normal arbitration resumes the next cycle.

Structure
REQ-030 A shared package uart_arb_pkg holds:
- state encodings S_IDLE, S_LOAD, S_WAIT;
- the N_REQ default;
- the ACK_TIMEOUT default;
- a clog2 function.
REQ-031 One sub-module, rr_arbiter, is used:
- inputs: request vector, pointer, lock and lock owner;
- output: one-hot winner;
- purely combinational.

Verification
REQ-032 Single request: reset, then REQ_VALID[0]=1 with data 0xAA and LAST=1, model uart_send with a 27 MHz CLK. Required: REQ_ACK[0] one cycle later, TX_DATA=0xAA with TX_DATA_READY until IDLE falls, and GRANT=0 after IDLE rises.
REQ-033 Round-robin: REQ_VALID=4'b1111 held continuously, all LAST=1. Required grant order 0,1,2,3,0 and exactly one ACK per byte.
REQ-034 Lock: requester 2 sends 0x4C (LAST=0) then 0x0D (LAST=1), with requester 0 valid throughout. Required: both bytes of requester 2 go out back-to-back before requester 0 is granted.
REQ-035 Timeout: TX_IDLE held at 1 with no accept, ACK_TIMEOUT=64. Required: TIMEOUT_ERR pulses exactly 64 cycles after entry to S_LOAD, TX_DATA_READY=0 and GRANT=0 the next cycle.
REQ-036 Busy UART: TX_IDLE=0 at request time. Required: no ACK until TX_IDLE=1, then ACK one cycle later.
REQ-037 Mid-transfer reset: RST pulsed for 2 cycles while in S_WAIT. Required: all outputs 0 during reset, and a fresh request is served from requester 0 priority afterwards.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM encoding, parameter defaults and a constant-evaluable clog2.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam int N_REQ_DEF       = 4;
  localparam int ACK_TIMEOUT_DEF = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot winner, search starts just after ptr.
// When locked, only the lock owner can win; zero latency, no backpressure of its own.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IW   = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic             lock,
  input  logic [IW-1:0]    lock_owner,
  output logic [N_REQ-1:0] gnt
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    if (lock) begin
      gnt[lock_owner] = req[lock_owner];
    end else begin
      // Wrap-around scan; the last-granted index is visited last.
      for (int i = 1; i <= N_REQ; i++) begin
        idx = IW'((int'(ptr) + i) % N_REQ);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_send among N_REQ byte requesters; ACK one cycle after VALID when the UART is idle.
// Backpressure: requesters hold VALID until ACK; a multi-byte message locks the UART to its owner.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   REQ_VALID,
  input  logic [8*N_REQ-1:0] REQ_DATA,
  input  logic [N_REQ-1:0]   REQ_LAST,
  output logic [N_REQ-1:0]   REQ_ACK,
  output logic [7:0]         TX_DATA,
  output logic               TX_DATA_READY,
  input  logic               TX_IDLE,
  output logic [N_REQ-1:0]   GRANT,
  output logic               BUSY,
  output logic               TIMEOUT_ERR
);

  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(ACK_TIMEOUT + 1);

  state_t           state, state_n;
  logic [7:0]       tx_data_q, tx_data_n;
  logic             rdy_q, rdy_n;
  logic [N_REQ-1:0] ack_q, ack_n;
  logic [N_REQ-1:0] grant_q, grant_n;
  logic             terr_q, terr_n;
  logic             lock_q, lock_n;
  logic [IW-1:0]    owner_q, owner_n;
  logic [IW-1:0]    ptr_q, ptr_n;
  logic [CW-1:0]    cnt_q, cnt_n;

  logic [N_REQ-1:0] win;
  logic [IW-1:0]    win_idx;
  logic [7:0]       sel_data;
  logic             sel_last;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (REQ_VALID),
    .ptr        (ptr_q),
    .lock       (lock_q),
    .lock_owner (owner_q),
    .gnt        (win)
  );

  always_comb begin
    win_idx  = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        win_idx  = IW'(i);
        sel_data = REQ_DATA[8*i +: 8];
        sel_last = REQ_LAST[i];
      end
    end
  end

  always_comb begin
    state_n   = state;
    tx_data_n = tx_data_q;
    rdy_n     = rdy_q;
    ack_n     = '0;
    grant_n   = grant_q;
    terr_n    = 1'b0;
    lock_n    = lock_q;
    owner_n   = owner_q;
    ptr_n     = ptr_q;
    cnt_n     = cnt_q;
    case (state)
      S_IDLE: begin
        if (TX_IDLE && (|win)) begin
          state_n   = S_LOAD;
          tx_data_n = sel_data;
          ack_n     = win;
          grant_n   = win;
          rdy_n     = 1'b1;
          cnt_n     = '0;
          ptr_n     = win_idx;
          owner_n   = win_idx;
          lock_n    = !sel_last;
        end
      end
      S_LOAD: begin
        if (!TX_IDLE) begin
          rdy_n   = 1'b0;
          state_n = S_WAIT;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          // UART never took the byte: drop it and release any message lock.
          rdy_n   = 1'b0;
          terr_n  = 1'b1;
          lock_n  = 1'b0;
          grant_n = '0;
          state_n = S_IDLE;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (TX_IDLE) begin
          state_n = S_IDLE;
          if (!lock_q) grant_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      tx_data_q <= '0;
      rdy_q     <= 1'b0;
      ack_q     <= '0;
      grant_q   <= '0;
      terr_q    <= 1'b0;
      lock_q    <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= IW'(N_REQ - 1);
      cnt_q     <= '0;
    end else begin
      state     <= state_n;
      tx_data_q <= tx_data_n;
      rdy_q     <= rdy_n;
      ack_q     <= ack_n;
      grant_q   <= grant_n;
      terr_q    <= terr_n;
      lock_q    <= lock_n;
      owner_q   <= owner_n;
      ptr_q     <= ptr_n;
      cnt_q     <= cnt_n;
    end
  end

  assign TX_DATA       = tx_data_q;
  assign TX_DATA_READY = rdy_q;
  assign REQ_ACK       = ack_q;
  assign GRANT         = grant_q;
  assign TIMEOUT_ERR   = terr_q;
  assign BUSY          = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table plus multi-cycle sequences
// (single request on a modelled uart_send, round-robin, timeout, mid-transfer reset).
module tb_uart_tx_arbiter;

  localparam int BYTE_CYC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid, last;
  logic [31:0] data;
  logic        manual_idle, model_en, model_idle, tx_idle;
  logic [3:0]  ack, grant;
  logic [7:0]  txd;
  logic        rdy, busy, terr;
  int          mcnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Roughly 27 MHz period in the nominal unit.
  always #19 clk = ~clk;

  assign tx_idle = model_en ? model_idle : manual_idle;

  uart_tx_arbiter #(.N_REQ(4), .ACK_TIMEOUT(64)) dut (
    .CLK           (clk),
    .RST           (rst),
    .REQ_VALID     (valid),
    .REQ_DATA      (data),
    .REQ_LAST      (last),
    .REQ_ACK       (ack),
    .TX_DATA       (txd),
    .TX_DATA_READY (rdy),
    .TX_IDLE       (tx_idle),
    .GRANT         (grant),
    .BUSY          (busy),
    .TIMEOUT_ERR   (terr)
  );

  // uart_send model: accepts on DATA_READY while idle, busy for BYTE_CYC cycles.
  always @(posedge clk) begin
    if (!model_en) begin
      model_idle <= 1'b1;
      mcnt       <= 0;
    end else if (model_idle) begin
      if (rdy) begin
        model_idle <= 1'b0;
        mcnt       <= BYTE_CYC;
      end
    end else if (mcnt == 0) begin
      model_idle <= 1'b1;
    end else begin
      mcnt <= mcnt - 1;
    end
  end

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        idle;
    logic [3:0]  e_ack;
    logic [3:0]  e_grant;
    logic [7:0]  e_txd;
    logic        e_rdy;
    logic        e_busy;
    logic        e_terr;
  } vec_t;

  vec_t tv[23];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] d,
                              input logic [3:0] l, input logic i, input logic [3:0] ea,
                              input logic [3:0] eg, input logic [7:0] ed, input logic er,
                              input logic eb, input logic et);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.last = l; t.idle = i;
    t.e_ack = ea; t.e_grant = eg; t.e_txd = ed; t.e_rdy = er; t.e_busy = eb; t.e_terr = et;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int k, got, bad;
    logic [3:0] e;

    rst = 1'b1; valid = '0; data = '0; last = '0;
    manual_idle = 1'b1; model_en = 1'b0;

    //           rst valid  data          last   idle | ack    grant  txd    rdy busy terr
    tv[0]  = mk(1, 4'b0000, 32'h0,        4'b0000, 1, 4'b0000, 4'b0000, 8'h00, 0, 0, 0);
    tv[1]  = mk(1, 4'b0001, 32'hAA,       4'b0001, 1, 4'b0000, 4'b0000, 8'h00, 0, 0, 0);
    tv[2]  = mk(0, 4'b0001, 32'hAA,       4'b0001, 1, 4'b0001, 4'b0001, 8'hAA, 1, 1, 0);
    tv[3]  = mk(0, 4'b0000, 32'hAA,       4'b0001, 0, 4'b0000, 4'b0001, 8'hAA, 0, 1, 0);
    tv[4]  = mk(0, 4'b0000, 32'hAA,       4'b0001, 0, 4'b0000, 4'b0001, 8'hAA, 0, 1, 0);
    tv[5]  = mk(0, 4'b0000, 32'hAA,       4'b0001, 1, 4'b0000, 4'b0000, 8'hAA, 0, 0, 0);
    tv[6]  = mk(0, 4'b0010, 32'h1100,     4'b0010, 0, 4'b0000, 4'b0000, 8'hAA, 0, 0, 0);
    tv[7]  = mk(0, 4'b0010, 32'h1100,     4'b0010, 0, 4'b0000, 4'b0000, 8'hAA, 0, 0, 0);
    tv[8]  = mk(0, 4'b0010, 32'h1100,     4'b0010, 1, 4'b0010, 4'b0010, 8'h11, 1, 1, 0);
    tv[9]  = mk(0, 4'b0000, 32'h1100,     4'b0010, 0, 4'b0000, 4'b0010, 8'h11, 0, 1, 0);
    tv[10] = mk(0, 4'b0000, 32'h0,        4'b0000, 1, 4'b0000, 4'b0000, 8'h11, 0, 0, 0);
    tv[11] = mk(0, 4'b0101, 32'h004C0055, 4'b0001, 1, 4'b0100, 4'b0100, 8'h4C, 1, 1, 0);
    tv[12] = mk(0, 4'b0001, 32'h004C0055, 4'b0001, 0, 4'b0000, 4'b0100, 8'h4C, 0, 1, 0);
    tv[13] = mk(0, 4'b0001, 32'h004C0055, 4'b0001, 1, 4'b0000, 4'b0100, 8'h4C, 0, 0, 0);
    tv[14] = mk(0, 4'b0001, 32'h004C0055, 4'b0001, 1, 4'b0000, 4'b0100, 8'h4C, 0, 0, 0);
    tv[15] = mk(0, 4'b0101, 32'h000D0055, 4'b0101, 1, 4'b0100, 4'b0100, 8'h0D, 1, 1, 0);
    tv[16] = mk(0, 4'b0001, 32'h000D0055, 4'b0101, 0, 4'b0000, 4'b0100, 8'h0D, 0, 1, 0);
    tv[17] = mk(0, 4'b0001, 32'h000D0055, 4'b0101, 1, 4'b0000, 4'b0000, 8'h0D, 0, 0, 0);
    tv[18] = mk(0, 4'b0001, 32'h00000055, 4'b0001, 1, 4'b0001, 4'b0001, 8'h55, 1, 1, 0);
    tv[19] = mk(0, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 4'b0001, 8'h55, 0, 1, 0);
    tv[20] = mk(0, 4'b0000, 32'h0,        4'b0000, 1, 4'b0000, 4'b0000, 8'h55, 0, 0, 0);
    tv[21] = mk(0, 4'b1000, 32'h77000000, 4'b1000, 0, 4'b0000, 4'b0000, 8'h55, 0, 0, 0);
    tv[22] = mk(0, 4'b0000, 32'h0,        4'b0000, 1, 4'b0000, 4'b0000, 8'h55, 0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      rst = tv[i].rst; valid = tv[i].valid; data = tv[i].data;
      last = tv[i].last; manual_idle = tv[i].idle;
      step();
      check($sformatf("vec%0d", i), {ack, grant, txd, rdy, busy, terr},
            {tv[i].e_ack, tv[i].e_grant, tv[i].e_txd, tv[i].e_rdy, tv[i].e_busy, tv[i].e_terr});
    end

    // Single request against the uart_send model.
    valid = '0; manual_idle = 1'b1;
    reset_pulse();
    model_en = 1'b1;
    valid = 4'b0001; data = 32'hAA; last = 4'b0001;
    step();
    check("sr_ack", ack, 4'b0001);
    valid = '0;
    k = 0; bad = 0;
    while (tx_idle && k < 50) begin
      if (!(rdy && txd == 8'hAA)) bad = 1;
      step(); k++;
    end
    check("sr_accept_in_time", k < 50, 1);
    check("sr_hold_data", bad, 0);
    k = 0;
    while (!tx_idle && k < 50) begin
      step(); k++;
    end
    check("sr_idle_in_time", k < 50, 1);
    step();
    check("sr_release", {grant, busy}, 5'b0);

    // Round-robin with every requester valid.
    reset_pulse();
    valid = 4'b1111; data = 32'hA3A2A1A0; last = 4'b1111;
    got = 0; k = 0;
    while (got < 5 && k < 500) begin
      step(); k++;
      if (ack != 4'b0000) begin
        e = 4'b0001 << (got % 4);
        check("rr_onehot", $countones(ack), 1);
        check($sformatf("rr_order%0d", got), {ack, grant}, {e, e});
        check($sformatf("rr_txd%0d", got), txd, 8'hA0 + 8'(got % 4));
        got++;
      end
    end
    check("rr_count", got, 5);
    valid = '0;
    k = 0;
    while (busy && k < 100) begin
      step(); k++;
    end
    check("rr_drain", busy, 0);
    model_en = 1'b0;

    // Accept timeout on a lock-opening byte.
    manual_idle = 1'b1;
    reset_pulse();
    valid = 4'b0001; data = 32'h5A; last = 4'b0000;
    step();
    check("to_ack", ack, 4'b0001);
    valid = '0;
    bad = 0;
    for (int c = 1; c <= 63; c++) begin
      step();
      if (terr || !rdy || txd != 8'h5A || grant != 4'b0001) bad = 1;
    end
    check("to_early", bad, 0);
    step();
    check("to_pulse", {terr, rdy, grant, busy}, {1'b1, 1'b0, 4'b0000, 1'b0});
    valid = 4'b0010; data = 32'h6600; last = 4'b0010;
    step();
    check("to_pulse_end", terr, 0);
    check("to_unlocked", ack, 4'b0010);
    valid = '0; manual_idle = 1'b0;
    step();
    manual_idle = 1'b1;
    step();

    // Reset while in S_WAIT.
    reset_pulse();
    valid = 4'b0100; data = 32'h00990000; last = 4'b0100;
    step();
    check("mr_ack", ack, 4'b0100);
    valid = '0; manual_idle = 1'b0;
    step();
    check("mr_wait", {grant, busy}, {4'b0100, 1'b1});
    rst = 1'b1;
    step();
    check("mr_rst1", {ack, grant, txd, rdy, busy, terr}, 19'b0);
    step();
    check("mr_rst2", {ack, grant, txd, rdy, busy, terr}, 19'b0);
    rst = 1'b0; manual_idle = 1'b1;
    valid = 4'b1111; data = 32'h44332211; last = 4'b1111;
    step();
    check("mr_after", {ack, txd}, {4'b0001, 8'h11});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
